alu_iterative: RTL and testbench

Multi-cycle RV64I execute unit that consumes the 4-bit `alu_funct` code produced by the ALU control decoder and returns a registered 64-bit result through a valid/ready handshake. Add, sub, compare and logic operations complete in one cycle. Shifts run through an iterative shifter, STEP bits per cycle, which trades latency for area. The unit sits in EX, between the operand muxes and the writeback/branch-resolve logic.

---
 rtl/alu_iterative_pkg.sv | 40 ++++
 rtl/alu_iterative_if.sv | 28 ++
 rtl/alu_shift_step.sv | 29 ++
 rtl/alu_iterative.sv | 165 ++++++++++++++++
 tb/tb_alu_iterative.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_iterative_pkg.sv
// Shared ALU encodings for the iterative execute unit: funct3 codes,
// FSM states and shifter directions.
package alu_iterative_pkg;

   localparam logic [2:0] ALU_ADD_SUB = 3'b000;
   localparam logic [2:0] ALU_SLL     = 3'b001;
   localparam logic [2:0] ALU_SLT     = 3'b010;
   localparam logic [2:0] ALU_SLTU    = 3'b011;
   localparam logic [2:0] ALU_XOR     = 3'b100;
   localparam logic [2:0] ALU_SHIFTR  = 3'b101;
   localparam logic [2:0] ALU_OR      = 3'b110;
   localparam logic [2:0] ALU_AND     = 3'b111;

   typedef struct packed {
      logic       secondary;
      logic [2:0] funct3;
   } alu_funct_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_t;

   typedef enum logic [1:0] {
      SH_LL = 2'd0,
      SH_RL = 2'd1,
      SH_RA = 2'd2
   } shift_dir_t;

   function automatic logic is_shift(input logic [2:0] funct3);
      return (funct3 == ALU_SLL) || (funct3 == ALU_SHIFTR);
   endfunction

   // The W variants only exist for add/sub and the shifts.
   function automatic logic word_applies(input logic [2:0] funct3);
      return (funct3 == ALU_ADD_SUB) || is_shift(funct3);
   endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// Request/response bundle between the EX operand muxes, the iterative ALU
// and the writeback/branch-resolve consumer.
interface alu_iterative_if
   import alu_iterative_pkg::*;
#(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   alu_funct_t      alu_funct;
   logic            word_op;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;

   modport master (
      output in_valid, alu_funct, word_op, operand_a, operand_b, out_ready,
      input  in_ready, out_valid, result, zero
   );

   modport slave (
      input  in_valid, alu_funct, word_op, operand_a, operand_b, out_ready,
      output in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/alu_shift_step.sv
// Purpose: one shifter slice, moves a value left/right by 0..STEP bits.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module alu_shift_step
   import alu_iterative_pkg::*;
#(
   parameter  int XLEN = 64,
   parameter  int STEP = 4,
   localparam int AMTW = $clog2(STEP) + 1
) (
   input  logic [XLEN-1:0] dat,
   input  logic [AMTW-1:0] amt,
   input  shift_dir_t      dir,
   input  logic            fill,
   output logic [XLEN-1:0] shifted
);
   logic [XLEN-1:0] fill_mask;

   always_comb begin
      fill_mask = ~({XLEN{1'b1}} >> amt);
      shifted   = dat;
      case (dir)
         SH_LL:   shifted = dat << amt;
         SH_RL:   shifted = dat >> amt;
         SH_RA:   shifted = (dat >> amt) | (fill ? fill_mask : '0);
         default: shifted = dat;
      endcase
   end
endmodule

// File: rtl/alu_iterative.sv
// Purpose: RV64I execute ALU; single-cycle arith/logic, iterative STEP-bit shifter.
// Latency: 1 cycle, or 1+ceil(shamt/STEP) for shifts with shamt>0.
// Backpressure: in_ready only in IDLE; result/zero held in DONE until out_ready.
module alu_iterative
   import alu_iterative_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int STEP = 4
) (
   input logic            clk,
   input logic            rst,
   alu_iterative_if.slave bus
);
   localparam int SHW  = $clog2(XLEN);
   localparam int AMTW = $clog2(STEP) + 1;

   alu_state_t      state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] work_q, work_d;
   logic            zero_q, zero_d;
   logic            word_q, word_d;
   logic            fill_q, fill_d;
   shift_dir_t      dir_q, dir_d;
   logic [SHW-1:0]  rem_q, rem_d;

   logic [XLEN-1:0] a, b, sum, alu_res, work_in, shifted, shift_res;
   logic [2:0]      f3;
   logic            sec, word, fill_in;
   logic [SHW-1:0]  shamt, rem_next;
   logic [AMTW-1:0] step_amt;
   shift_dir_t      dir_in;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

   assign a     = bus.operand_a;
   assign b     = bus.operand_b;
   assign f3    = bus.alu_funct.funct3;
   assign sec   = bus.alu_funct.secondary;
   assign word  = bus.word_op & word_applies(f3);
   assign shamt = word ? SHW'(b[4:0]) : b[SHW-1:0];

   // Single-cycle results; a zero-distance shift just passes A through.
   always_comb begin
      sum     = sec ? a - b : a + b;
      alu_res = '0;
      case (f3)
         ALU_ADD_SUB:     alu_res = word ? sext32(sum[31:0]) : sum;
         ALU_SLL,
         ALU_SHIFTR:      alu_res = word ? sext32(a[31:0]) : a;
         ALU_SLT:         alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU:        alu_res = {{(XLEN-1){1'b0}}, a < b};
         ALU_XOR:         alu_res = a ^ b;
         ALU_OR:          alu_res = a | b;
         ALU_AND:         alu_res = a & b;
         default:         alu_res = '0;
      endcase
   end

   // W right shifts pre-load the 32-bit field so bits entering from the top
   // already carry the right fill; the final sext32 discards the upper half.
   always_comb begin
      dir_in  = SH_LL;
      work_in = a;
      fill_in = 1'b0;
      if (f3 == ALU_SHIFTR) begin
         if (sec) begin
            dir_in  = SH_RA;
            fill_in = word ? a[31] : a[XLEN-1];
            if (word) work_in = sext32(a[31:0]);
         end else begin
            dir_in = SH_RL;
            if (word) work_in = {{(XLEN-32){1'b0}}, a[31:0]};
         end
      end
   end

   assign step_amt  = (int'(rem_q) > STEP) ? AMTW'(STEP) : AMTW'(rem_q);
   assign rem_next  = rem_q - SHW'(step_amt);
   assign shift_res = word_q ? sext32(shifted[31:0]) : shifted;

   alu_shift_step #(
      .XLEN (XLEN),
      .STEP (STEP)
   ) u_shift_step (
      .dat     (work_q),
      .amt     (step_amt),
      .dir     (dir_q),
      .fill    (fill_q),
      .shifted (shifted)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      work_d   = work_q;
      rem_d    = rem_q;
      dir_d    = dir_q;
      fill_d   = fill_q;
      word_d   = word_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (!is_shift(f3) || (shamt == '0)) begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  state_d  = ST_DONE;
               end else begin
                  work_d  = work_in;
                  rem_d   = shamt;
                  dir_d   = dir_in;
                  fill_d  = fill_in;
                  word_d  = word;
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            work_d = shifted;
            rem_d  = rem_next;
            if (rem_next == '0) begin
               result_d = shift_res;
               zero_d   = (shift_res == '0);
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         work_q   <= '0;
         rem_q    <= '0;
         dir_q    <= SH_LL;
         fill_q   <= 1'b0;
         word_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         work_q   <= work_d;
         rem_q    <= rem_d;
         dir_q    <= dir_d;
         fill_q   <= fill_d;
         word_q   <= word_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_iterative.sv
// Randomised and directed stimulus for alu_iterative, checked against an
// arithmetic reference of the RV64I operations and the latency formula.
module tb_alu_iterative;
   localparam int XLEN = 64;
   localparam int STEP = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   alu_iterative_if #(.XLEN(XLEN)) bus ();

   alu_iterative #(
      .XLEN (XLEN),
      .STEP (STEP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_alu(input logic [3:0] fn, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      logic [31:0] t, a32, b32;
      int          sh;
      a32 = a[31:0];
      b32 = b[31:0];
      sh  = w ? int'(b[4:0]) : int'(b[5:0]);
      r   = '0;
      t   = '0;
      case (fn[2:0])
         3'b000: begin
            r = fn[3] ? a - b : a + b;
            t = fn[3] ? a32 - b32 : a32 + b32;
         end
         3'b001: begin
            r = a << sh;
            t = a32 << sh;
         end
         3'b010: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         3'b011: return (a < b) ? 64'd1 : 64'd0;
         3'b100: return a ^ b;
         3'b110: return a | b;
         3'b111: return a & b;
         default: begin
            if (fn[3]) begin
               r = $signed(a) >>> sh;
               t = $signed(a32) >>> sh;
            end else begin
               r = a >> sh;
               t = a32 >> sh;
            end
         end
      endcase
      return w ? {{32{t[31]}}, t} : r;
   endfunction

   function automatic int ref_lat(input logic [3:0] fn, input logic w, input logic [63:0] b);
      int sh;
      sh = w ? int'(b[4:0]) : int'(b[5:0]);
      if ((fn[2:0] == 3'b001 || fn[2:0] == 3'b101) && sh != 0)
         return 1 + (sh + STEP - 1) / STEP;
      return 1;
   endfunction

   // Starts and ends on a falling edge; hold = cycles out_ready stays low in DONE.
   task automatic run_op(input string tag, input logic [3:0] fn, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input int hold);
      logic [63:0] exp;
      logic [63:0] r0;
      logic        z0;
      int          lat;
      exp = ref_alu(fn, w, a, b);
      check_eq({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid  = 1'b1;
      bus.alu_funct = fn;
      bus.word_op   = w;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.operand_a = {$urandom, $urandom};
      bus.operand_b = {$urandom, $urandom};
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check_eq({tag, ".latency"}, 64'(lat), 64'(ref_lat(fn, w, b)));
      check_eq({tag, ".result"}, bus.result, exp);
      check_eq({tag, ".zero"}, 64'(bus.zero), 64'(exp == 64'd0));
      r0 = bus.result;
      z0 = bus.zero;
      for (int i = 0; i < hold; i++) begin
         bus.in_valid  = 1'b1;
         bus.alu_funct = 4'($urandom);
         bus.operand_a = {$urandom, $urandom};
         @(negedge clk);
         check_eq({tag, ".hold_result"}, bus.result, r0);
         check_eq({tag, ".hold_zero"}, 64'(bus.zero), 64'(z0));
         check_eq({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
         check_eq({tag, ".hold_out_valid"}, 64'(bus.out_valid), 64'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, ".post_out_valid"}, 64'(bus.out_valid), 64'd0);
      check_eq({tag, ".post_in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a, b;
      logic [3:0]  fn;
      logic        w;
      bus.in_valid  = 1'b0;
      bus.alu_funct = 4'd0;
      bus.word_op   = 1'b0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset.in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("reset.out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("reset.result", bus.result, 64'd0);
      check_eq("reset.zero", 64'(bus.zero), 64'd0);
      rst = 1'b0;

      run_op("add",  4'b0000, 1'b0, 64'd5, 64'd7, 0);
      run_op("sub",  4'b1000, 1'b0, 64'd9, 64'd9, 0);
      run_op("slt",  4'b0010, 1'b0, '1, 64'd1, 0);
      run_op("sltu", 4'b0011, 1'b0, '1, 64'd1, 0);
      run_op("xor",  4'b1100, 1'b0, 64'hF0, 64'hFF, 0);
      run_op("sra63", 4'b1101, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 0);
      run_op("sll0", 4'b0001, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
      run_op("addw", 4'b0000, 1'b1, 64'h7FFF_FFFF, 64'd1, 0);
      run_op("srlw", 4'b0101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 0);
      run_op("sraw", 4'b1101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 0);
      run_op("bp_add", 4'b0000, 1'b0, 64'd3, 64'd4, 5);

      // Abort a long shift mid-flight; the previous result was non-zero.
      bus.in_valid  = 1'b1;
      bus.alu_funct = 4'b0001;
      bus.word_op   = 1'b0;
      bus.operand_a = 64'hDEAD_BEEF_0000_0001;
      bus.operand_b = 64'd40;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_mid.busy", 64'(bus.in_ready), 64'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b0;
      check_eq("rst_mid.in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("rst_mid.out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_mid.result", bus.result, 64'd0);
      check_eq("rst_mid.zero", 64'(bus.zero), 64'd0);
      run_op("add_after_rst", 4'b0000, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 0);

      for (int i = 0; i < 200; i++) begin
         fn = 4'($urandom_range(0, 15));
         w  = 1'($urandom_range(0, 1));
         a  = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       b = {$urandom, $urandom};
            1:       b = 64'($urandom_range(0, 70));
            2:       b = a;
            default: b = '1;
         endcase
         run_op("rand", fn, w, a, b, $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
